unary_add_seq_ctrl: RTL and testbench



---
 rtl/unary_add_seq_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_unary_add_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_add_seq_ctrl.sv
// Round-robin sequencer for a mod-MOD unary pulse adder: streams a granted operand
// pair as pulses, drains the resulting digit back and returns it as sum/carry.
module unary_add_seq_ctrl #(
    parameter int  N_REQ = 2,
    parameter int  W     = 3,
    parameter int  MOD   = 6,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output logic [W-1:0]       rsp_sum,
    output logic               rsp_carry,
    output logic               rsp_err,
    output logic               add_en,
    output logic               add_rw,
    output logic               add_a,
    output logic               add_b,
    input  logic               add_dout,
    input  logic               add_c
);

    localparam int            DW        = $clog2(MOD + 3);
    localparam logic [W:0]    MOD_V     = (W + 1)'(MOD);
    localparam logic [DW-1:0] DRAIN_TWO = DW'(2);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(MOD + 2);

    typedef enum logic [2:0] {IDLE, FEED, TAIL, DRAIN, RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [IW-1:0] id_q, id_d;
    logic [W-1:0]  beat_q, beat_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          prev_read_q;

    logic [N_REQ-1:0] ready_d;
    logic             en_d, rw_d, pa_d, pb_d;
    logic             rsp_valid_d, rsp_carry_d, rsp_err_d;
    logic [IW-1:0]    rsp_id_d;
    logic [W-1:0]     rsp_sum_d;

    logic          found;
    logic [IW-1:0] gnt_idx;
    logic [W-1:0]  gnt_a, gnt_b;
    logic          gnt_bad;
    logic [W:0]    sum_full, exp_sum;
    logic          exp_carry;
    logic [W-1:0]  max_ab, beat_nx;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(rr_q) + k) % N_REQ]) begin
                found   = 1'b1;
                gnt_idx = IW'((int'(rr_q) + k) % N_REQ);
            end
        end
    end

    assign gnt_a   = req_a[int'(gnt_idx)*W +: W];
    assign gnt_b   = req_b[int'(gnt_idx)*W +: W];
    assign gnt_bad = ({1'b0, gnt_a} >= MOD_V) || ({1'b0, gnt_b} >= MOD_V);

    assign sum_full  = {1'b0, a_q} + {1'b0, b_q};
    assign exp_carry = (sum_full >= MOD_V);
    assign exp_sum   = exp_carry ? (sum_full - MOD_V) : sum_full;
    assign max_ab    = (a_q > b_q) ? a_q : b_q;
    assign beat_nx   = beat_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        rr_d        = rr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        beat_d      = beat_q;
        drain_d     = drain_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q | (prev_read_q & add_c);
        ready_d     = '0;
        en_d        = 1'b0;
        rw_d        = 1'b0;
        pa_d        = 1'b0;
        pb_d        = 1'b0;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_sum_d   = rsp_sum;
        rsp_carry_d = rsp_carry;
        rsp_err_d   = rsp_err;

        unique case (state_q)
            IDLE: begin
                if (found && !rsp_valid) begin
                    ready_d[gnt_idx] = 1'b1;
                    a_d     = gnt_a;
                    b_d     = gnt_b;
                    id_d    = gnt_idx;
                    rr_d    = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    beat_d  = '0;
                    drain_d = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    if (gnt_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = gnt_idx;
                        rsp_sum_d   = '0;
                        rsp_carry_d = 1'b0;
                        rsp_err_d   = 1'b1;
                    end else if (gnt_a != '0 || gnt_b != '0) begin
                        state_d = FEED;
                        en_d    = 1'b1;
                        pa_d    = (gnt_a != '0);
                        pb_d    = (gnt_b != '0);
                    end else begin
                        state_d = TAIL;
                    end
                end
            end
            FEED: begin
                if (beat_nx < max_ab) begin
                    beat_d = beat_nx;
                    en_d   = 1'b1;
                    pa_d   = (beat_nx < a_q);
                    pb_d   = (beat_nx < b_q);
                end else begin
                    state_d = TAIL;
                end
            end
            TAIL: begin
                state_d = DRAIN;
                drain_d = DW'(1);
                en_d    = 1'b1;
                rw_d    = 1'b1;
            end
            DRAIN: begin
                // A drain pulse trails its write beat by one cycle, so the first cycle is never judged.
                if (drain_q >= DRAIN_TWO && !add_dout) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_sum_d   = cnt_q;
                    rsp_carry_d = carry_q;
                    rsp_err_d   = ({1'b0, cnt_q} != exp_sum) || (carry_q != exp_carry);
                end else if (drain_q >= DRAIN_MAX) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_sum_d   = cnt_q;
                    rsp_carry_d = carry_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    if (drain_q >= DRAIN_TWO) cnt_d = cnt_q + 1'b1;
                    drain_d = drain_q + 1'b1;
                    en_d    = 1'b1;
                    rw_d    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            beat_q      <= '0;
            drain_q     <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            prev_read_q <= 1'b0;
            req_ready   <= '0;
            add_en      <= 1'b0;
            add_rw      <= 1'b0;
            add_a       <= 1'b0;
            add_b       <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_sum     <= '0;
            rsp_carry   <= 1'b0;
            rsp_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            rr_q        <= rr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            prev_read_q <= add_en & ~add_rw;
            req_ready   <= ready_d;
            add_en      <= en_d;
            add_rw      <= rw_d;
            add_a       <= pa_d;
            add_b       <= pb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_id      <= rsp_id_d;
            rsp_sum     <= rsp_sum_d;
            rsp_carry   <= rsp_carry_d;
            rsp_err     <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_unary_add_seq_ctrl.sv
// Bench for unary_add_seq_ctrl: behavioural unary adder with fault modes, plus an
// arithmetic reference model for responses, latency and beat counts.
module tb_unary_add_seq_ctrl;

    localparam int N_REQ = 2;
    localparam int W     = 3;
    localparam int MOD   = 6;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_a, req_b;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid, rsp_ready;
    logic [0:0]         rsp_id;
    logic [W-1:0]       rsp_sum;
    logic               rsp_carry, rsp_err;
    logic               add_en, add_rw, add_a, add_b, add_dout, add_c;

    int n_cmp = 0;
    int n_bad = 0;
    bit f_drop  = 1'b0;
    bit f_stuck = 1'b0;
    int rd_tot = 0, en_tot = 0, dout_tot = 0;

    typedef struct {
        int ok, id, sum, carry, err, lat, rd, en, dout, stable, cleared;
    } obs_t;

    unary_add_seq_ctrl #(.N_REQ(N_REQ), .W(W), .MOD(MOD)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .add_en(add_en), .add_rw(add_rw), .add_a(add_a), .add_b(add_b),
        .add_dout(add_dout), .add_c(add_c)
    );

    always #5 clk = ~clk;

    // Unary adder: count accumulates pulses mod MOD; each write beat emits one drain pulse.
    int acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 0; add_c <= 1'b0; add_dout <= 1'b0;
        end else begin
            add_c    <= 1'b0;
            add_dout <= f_stuck;
            if (add_en && !add_rw) begin
                if (acc + int'(add_a) + int'(add_b) >= MOD) begin
                    acc   <= acc + int'(add_a) + int'(add_b) - MOD;
                    add_c <= 1'b1;
                end else begin
                    acc <= acc + int'(add_a) + int'(add_b);
                end
            end else if (add_en && add_rw && acc > 0) begin
                acc <= acc - 1;
                if (!(f_drop && acc == 1)) add_dout <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (add_en && !add_rw) rd_tot++;
        if (add_en) en_tot++;
        if (add_dout) dout_tot++;
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    function automatic obs_t model(input int a, input int b);
        obs_t e;
        int m, s;
        bit lg;
        lg = (a < MOD) && (b < MOD);
        m  = (a > b) ? a : b;
        s  = (a + b) % MOD;
        e  = '{default: 0};
        e.ok = 1; e.stable = 1; e.cleared = 1;
        e.sum   = lg ? s : 0;
        e.carry = (lg && a + b >= MOD) ? 1 : 0;
        e.err   = lg ? 0 : 1;
        e.lat   = lg ? m + s + 4 : 1;
        e.rd    = lg ? m : 0;
        e.en    = lg ? m + s + 2 : 0;
        e.dout  = lg ? s : 0;
        return e;
    endfunction

    task automatic run_req(input int id, input int a, input int b, input int stall, output obs_t o);
        int en0, rd0, dout0, n;
        logic [5:0] snap;
        o = '{default: 0};
        step;
        req_a[id*W +: W] = W'(a);
        req_b[id*W +: W] = W'(b);
        req_valid[id] = 1'b1;
        en0 = en_tot; rd0 = rd_tot; dout0 = dout_tot;
        n = 0;
        do begin step; n++; end while (!req_ready[id] && n < 50);
        req_valid[id] = 1'b0;
        if (!req_ready[id]) return;
        o.lat = 1;
        while (!rsp_valid && o.lat < 100) begin step; o.lat++; end
        if (!rsp_valid) return;
        o.ok = 1; o.id = int'(rsp_id); o.sum = int'(rsp_sum);
        o.carry = int'(rsp_carry); o.err = int'(rsp_err);
        o.rd = rd_tot - rd0; o.en = en_tot - en0; o.dout = dout_tot - dout0;
        snap = {rsp_id, rsp_sum, rsp_carry, rsp_err};
        o.stable = 1;
        for (int i = 0; i < stall; i++) begin
            step;
            if (!rsp_valid || {rsp_id, rsp_sum, rsp_carry, rsp_err} !== snap || req_ready !== '0) o.stable = 0;
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        o.cleared = rsp_valid ? 0 : 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) step;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err, add_en, add_rw, add_a, add_b} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 0", {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err, add_en, add_rw, add_a, add_b});
        end
        rst_n = 1'b1;
        repeat (3) step;
        n_cmp++;
        if ({req_ready, rsp_valid, add_en} !== '0) begin
            n_bad++; $display("FAIL idle_after_reset: got %b want 0", {req_ready, rsp_valid, add_en});
        end
    endtask

    task automatic test_directed;
        int t_id[7] = '{0, 1, 1, 0, 0, 1, 0};
        int t_a[7]  = '{2, 4, 5, 0, 6, 3, 5};
        int t_b[7]  = '{3, 5, 5, 0, 1, 7, 0};
        obs_t o, e;
        for (int i = 0; i < 7; i++) begin
            run_req(t_id[i], t_a[i], t_b[i], i % 3, o);
            e = model(t_a[i], t_b[i]);
            n_cmp++; if (o.ok != 1) begin n_bad++; $display("FAIL dir%0d handshake: got %0d want 1", i, o.ok); end
            n_cmp++; if (o.id != t_id[i]) begin n_bad++; $display("FAIL dir%0d id: got %0d want %0d", i, o.id, t_id[i]); end
            n_cmp++; if (o.sum != e.sum) begin n_bad++; $display("FAIL dir%0d sum: got %0d want %0d", i, o.sum, e.sum); end
            n_cmp++; if (o.carry != e.carry) begin n_bad++; $display("FAIL dir%0d carry: got %0d want %0d", i, o.carry, e.carry); end
            n_cmp++; if (o.err != e.err) begin n_bad++; $display("FAIL dir%0d err: got %0d want %0d", i, o.err, e.err); end
            n_cmp++; if (o.lat != e.lat) begin n_bad++; $display("FAIL dir%0d latency: got %0d want %0d", i, o.lat, e.lat); end
            n_cmp++; if (o.rd != e.rd) begin n_bad++; $display("FAIL dir%0d read_beats: got %0d want %0d", i, o.rd, e.rd); end
            n_cmp++; if (o.en != e.en) begin n_bad++; $display("FAIL dir%0d en_beats: got %0d want %0d", i, o.en, e.en); end
            n_cmp++; if (o.dout != e.dout) begin n_bad++; $display("FAIL dir%0d dout_pulses: got %0d want %0d", i, o.dout, e.dout); end
            n_cmp++; if (o.stable != 1 || o.cleared != 1) begin n_bad++; $display("FAIL dir%0d rsp_hold: got stable=%0d cleared=%0d want 1/1", i, o.stable, o.cleared); end
        end
    endtask

    task automatic test_random;
        obs_t o, e;
        int id, a, b;
        for (int i = 0; i < 30; i++) begin
            id = int'($urandom_range(0, N_REQ - 1));
            a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MOD, 7)) : int'($urandom_range(0, MOD - 1));
            b  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MOD, 7)) : int'($urandom_range(0, MOD - 1));
            run_req(id, a, b, int'($urandom_range(0, 3)), o);
            e = model(a, b);
            n_cmp++;
            if (o.ok != 1 || o.id != id || o.sum != e.sum || o.carry != e.carry || o.err != e.err) begin
                n_bad++;
                $display("FAIL rnd%0d a=%0d b=%0d rsp: got ok=%0d id=%0d sum=%0d c=%0d err=%0d want 1/%0d/%0d/%0d/%0d",
                         i, a, b, o.ok, o.id, o.sum, o.carry, o.err, id, e.sum, e.carry, e.err);
            end
            n_cmp++;
            if (o.lat != e.lat || o.rd != e.rd || o.en != e.en || o.dout != e.dout) begin
                n_bad++;
                $display("FAIL rnd%0d a=%0d b=%0d timing: got lat=%0d rd=%0d en=%0d dout=%0d want %0d/%0d/%0d/%0d",
                         i, a, b, o.lat, o.rd, o.en, o.dout, e.lat, e.rd, e.en, e.dout);
            end
            n_cmp++;
            if (o.stable != 1 || o.cleared != 1) begin
                n_bad++; $display("FAIL rnd%0d rsp_hold: got stable=%0d cleared=%0d want 1/1", i, o.stable, o.cleared);
            end
        end
    endtask

    task automatic test_back_to_back;
        int op_a[2] = '{1, 4};
        int op_b[2] = '{2, 4};
        int rr = 0, exp_id, n;
        bit stable;
        logic [5:0] snap;
        step; rst_n = 1'b0; step; rst_n = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*W +: W] = W'(op_a[i]);
            req_b[i*W +: W] = W'(op_b[i]);
        end
        req_valid = '1;
        for (int g = 0; g < 4; g++) begin
            exp_id = rr;
            rr = (rr + 1) % N_REQ;
            n = 0;
            do begin step; n++; end while (req_ready === '0 && n < 50);
            n_cmp++;
            if (req_ready !== N_REQ'(1 << exp_id)) begin
                n_bad++; $display("FAIL b2b%0d grant: got %b want %b", g, req_ready, N_REQ'(1 << exp_id));
            end
            n = 0;
            while (!rsp_valid && n < 100) begin step; n++; end
            n_cmp++;
            if (rsp_valid !== 1'b1 || int'(rsp_id) != exp_id || int'(rsp_sum) != (op_a[exp_id] + op_b[exp_id]) % MOD
                || int'(rsp_carry) != ((op_a[exp_id] + op_b[exp_id] >= MOD) ? 1 : 0) || rsp_err !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b%0d rsp: got v=%b id=%0d sum=%0d c=%b err=%b want 1/%0d/%0d/%0d/0", g, rsp_valid, rsp_id,
                         rsp_sum, rsp_carry, rsp_err, exp_id, (op_a[exp_id] + op_b[exp_id]) % MOD,
                         (op_a[exp_id] + op_b[exp_id] >= MOD) ? 1 : 0);
            end
            snap = {rsp_id, rsp_sum, rsp_carry, rsp_err};
            stable = 1'b1;
            for (int s = 0; s < 3; s++) begin
                step;
                if (!rsp_valid || {rsp_id, rsp_sum, rsp_carry, rsp_err} !== snap || req_ready !== '0) stable = 1'b0;
            end
            n_cmp++;
            if (!stable) begin n_bad++; $display("FAIL b2b%0d stall_hold: got unstable want stable", g); end
            if (g == 3) req_valid = '0;
            rsp_ready = 1'b1;
            step;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        int n = 0;
        step;
        req_a[W-1:0] = W'(3); req_b[W-1:0] = W'(2); req_valid[0] = 1'b1;
        do begin step; n++; end while (!req_ready[0] && n < 50);
        req_valid[0] = 1'b0;
        n = 0;
        while (!(add_en && add_rw) && n < 50) begin step; n++; end
        step;
        n_cmp++;
        if (!(add_en && add_rw)) begin n_bad++; $display("FAIL midrst_in_drain: got en=%b rw=%b want 1/1", add_en, add_rw); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err, add_en, add_rw, add_a, add_b} !== '0) begin
            n_bad++; $display("FAIL midrst_outputs: got %b want 0", {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err, add_en, add_rw, add_a, add_b});
        end
        step;
        rst_n = 1'b1;
        run_req(0, 1, 1, 1, o);
        n_cmp++;
        if (o.ok != 1 || o.sum != 2 || o.carry != 0 || o.err != 0 || o.lat != 7) begin
            n_bad++; $display("FAIL midrst_recover: got ok=%0d sum=%0d c=%0d err=%0d lat=%0d want 1/2/0/0/7", o.ok, o.sum, o.carry, o.err, o.lat);
        end
    endtask

    task automatic test_faults;
        obs_t o;
        f_drop = 1'b1;
        run_req(1, 2, 2, 0, o);
        f_drop = 1'b0;
        n_cmp++;
        if (o.ok != 1 || o.err != 1 || o.sum != 3) begin
            n_bad++; $display("FAIL drop_pulse: got ok=%0d err=%0d sum=%0d want 1/1/3", o.ok, o.err, o.sum);
        end
        f_stuck = 1'b1;
        run_req(0, 1, 2, 1, o);
        f_stuck = 1'b0;
        n_cmp++;
        if (o.ok != 1 || o.err != 1 || o.cleared != 1) begin
            n_bad++; $display("FAIL stuck_timeout: got ok=%0d err=%0d cleared=%0d want 1/1/1", o.ok, o.err, o.cleared);
        end
        run_req(1, 3, 3, 0, o);
        n_cmp++;
        if (o.ok != 1 || o.sum != 0 || o.carry != 1 || o.err != 0 || o.lat != 7) begin
            n_bad++; $display("FAIL fault_recover: got ok=%0d sum=%0d c=%0d err=%0d lat=%0d want 1/0/1/0/7", o.ok, o.sum, o.carry, o.err, o.lat);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_mid;
        test_faults;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
